// File: rtl/arf_pull_source_pkg.sv
// arf_pull_source_pkg
//  Shared definitions for the arf pull-source slice: delivered-word counter
//  width, a constant clog2 helper for sizing pointers and occupancy, and the
//  arf operator op-codes/strings shared by graphs and benches.
package arf_pull_source_pkg;

  localparam int unsigned ARF_COUNT_W = 32;

  typedef enum logic [1:0] {
    ARF_OP_IN   = 2'd0,
    ARF_OP_OUT  = 2'd1,
    ARF_OP_MAP  = 2'd2,
    ARF_OP_SINK = 2'd3
  } arf_op_e;

  localparam logic [8*4-1:0] ARF_OP_STR_IN   = "in";
  localparam logic [8*4-1:0] ARF_OP_STR_OUT  = "out";
  localparam logic [8*4-1:0] ARF_OP_STR_MAP  = "map";
  localparam logic [8*4-1:0] ARF_OP_STR_SINK = "sink";

  // Smallest r with 2**r >= v (v >= 1).
  function automatic int unsigned arf_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arf_sync_fifo.sv
// arf_sync_fifo
//  Single-clock FIFO with registered occupancy. Writes into a full FIFO and
//  reads from an empty FIFO are ignored. rd_data shows the head word
//  combinationally; it is only meaningful while empty=0.
// Ports:
//  clk, rst           clock, asynchronous active-high reset
//  wr_en, wr_data     write strobe and word
//  rd_en, rd_data     pop strobe and head word
//  level              occupancy, 0..depth
//  full, empty        occupancy flags decoded from level
module arf_sync_fifo
  import arf_pull_source_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [data_width-1:0]        wr_data,
  input  logic                         rd_en,
  output logic [data_width-1:0]        rd_data,
  output logic [arf_clog2(depth):0]    level,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = arf_clog2(depth);
  localparam int unsigned LW = AW + 1;

  logic [data_width-1:0] mem [depth];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr;
  logic                  rd;

  assign full  = (level == LW'(depth));
  assign empty = (level == '0);
  assign wr    = wr_en & ~full;
  assign rd    = rd_en & ~empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  // depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/arf_pull_source.sv
// arf_pull_source
//  Responder end of the arf req/ack pull protocol. Words arrive on a
//  valid/ready stream into an arf_sync_fifo and are handed out one per ack to
//  output_size requesters; a word is issued only when every req bit is set.
//  ack is a registered one-cycle pulse and is never issued on two consecutive
//  cycles, so a requester holding req through its ack gets no duplicate.
//  Build option: ARF_PULL_SOURCE_BYPASS_EN -- when the FIFO is empty and a
//  pull is pending, an incoming word goes straight to dout on the edge it is
//  presented, without being written to the FIFO.
// Ports:
//  clk, rst           clock, asynchronous active-high reset
//  s_valid/s_ready/s_data  upstream stream (s_ready from registered state)
//  req                pull request, one bit per requester
//  ack                word delivered this cycle
//  dout               delivered word, held after ack
//  count              words delivered since reset (wraps)
//  level              FIFO occupancy
module arf_pull_source
  import arf_pull_source_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned depth       = 8,
  parameter int unsigned output_size = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [data_width-1:0]        s_data,
  input  logic [output_size-1:0]       req,
  output logic                         ack,
  output logic [data_width-1:0]        dout,
  output logic [ARF_COUNT_W-1:0]       count,
  output logic [arf_clog2(depth):0]    level
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_wr;
  logic                  fifo_rd;
  logic [data_width-1:0] head;
  logic                  push;
  logic                  want;
  logic                  issue;
  logic [data_width-1:0] issue_data;

  arf_sync_fifo #(
    .data_width (data_width),
    .depth      (depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (s_data),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Full is judged before any same-edge pop, so a full FIFO never takes a push.
  assign s_ready = ~fifo_full;
  assign push    = s_valid & s_ready;
  // ~ack spaces issues two cycles apart.
  assign want    = (&req) & ~ack;
  assign fifo_rd = want & ~fifo_empty;

`ifdef ARF_PULL_SOURCE_BYPASS_EN
  logic bypass;

  // Only taken on an empty FIFO, so ordering matches the FIFO path.
  assign bypass     = want & fifo_empty & s_valid;
  assign fifo_wr    = push & ~bypass;
  assign issue      = fifo_rd | bypass;
  assign issue_data = fifo_empty ? s_data : head;
`else
  assign fifo_wr    = push;
  assign issue      = fifo_rd;
  assign issue_data = head;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack   <= 1'b0;
      dout  <= '0;
      count <= '0;
    end else begin
      ack <= issue;
      if (issue) begin
        dout  <= issue_data;
        count <= count + ARF_COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_arf_pull_source.sv
// tb_arf_pull_source
//  Directed bench for arf_pull_source (data_width=32, depth=8, output_size=3).
//  Accepted words are queued as expected deliveries; every ack pops the queue
//  and checks dout and the running count.
module tb_arf_pull_source;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NREQ  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_valid;
  logic            s_ready;
  logic [DW-1:0]   s_data;
  logic [NREQ-1:0] req;
  logic            ack;
  logic [DW-1:0]   dout;
  logic [31:0]     count;
  logic [3:0]      level;

  int comps = 0;
  int fails = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  logic [31:0]   exp_count = '0;
  int            acks_seen = 0;
  int            accepted  = 0;
  int            n_acks;
  int            last_ack;
  int            gaps_ok;
  int            saw;

  always #5 clk = ~clk;

  arf_pull_source #(
    .data_width  (DW),
    .depth       (DEPTH),
    .output_size (NREQ)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .req     (req),
    .ack     (ack),
    .dout    (dout),
    .count   (count),
    .level   (level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    comps++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Called just after a falling edge; s_ready is stable until the next rise.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [NREQ-1:0] r);
    s_valid = v;
    s_data  = d;
    req     = r;
    if (v && s_ready) begin
      exp_q.push_back(d);
      accepted++;
    end
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && ack) begin
      acks_seen++;
      mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
      exp_count = exp_count + 32'd1;
      check("ack_dout", 64'(dout), 64'(mon_exp));
      check("ack_count", 64'(count), 64'(exp_count));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; req = '0;
    cyc(); cyc();
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    rst = 1'b0;

    // Single word
    cyc(); drive(1'b1, 32'h5, '1);
    cyc(); drive(1'b0, '0, '1);
`ifdef ARF_PULL_SOURCE_BYPASS_EN
    check("t1_ack_first", 64'(ack), 64'd1);
`else
    check("t1_ack_first", 64'(ack), 64'd0);
`endif
    cyc();
`ifdef ARF_PULL_SOURCE_BYPASS_EN
    check("t1_ack_second", 64'(ack), 64'd0);
`else
    check("t1_ack_second", 64'(ack), 64'd1);
`endif
    repeat (3) begin cyc(); check("t1_no_dup", 64'(ack), 64'd0); end
    check("t1_count", 64'(count), 64'd1);
    check("t1_dout_hold", 64'(dout), 64'h5);
    check("t1_acks", 64'(acks_seen), 64'd1);
    drive(1'b0, '0, '0);

    // Fill and backpressure
    accepted = 0;
    for (int i = 0; i < 10; i++) begin cyc(); drive(1'b1, DW'(i), '0); end
    cyc();
    check("t2_accepted", 64'(accepted), 64'd8);
    check("t2_level_full", 64'(level), 64'd8);
    check("t2_s_ready_full", 64'(s_ready), 64'd0);
    drive(1'b1, 32'hFF, '1);
    cyc();
    check("t2_first_ack", 64'(ack), 64'd1);
    check("t2_s_ready_after_pop", 64'(s_ready), 64'd1);
    check("t2_level_after_pop", 64'(level), 64'd7);
    drive(1'b0, '0, '1);
    n_acks = 1; last_ack = 0; gaps_ok = 1;
    for (int t = 1; t < 40; t++) begin
      cyc();
      if (ack) begin
        if (t - last_ack != 2) gaps_ok = 0;
        last_ack = t;
        n_acks++;
      end
    end
    check("t2_acks", 64'(n_acks), 64'd8);
    check("t2_spacing", 64'(gaps_ok), 64'd1);
    check("t2_level_empty", 64'(level), 64'd0);
    drive(1'b0, '0, '0);

    // Push and pop on the same edge
    cyc(); drive(1'b1, 32'h51, '0);
    cyc();
    check("pp_level_pre", 64'(level), 64'd1);
    drive(1'b1, 32'h52, '1);
    cyc();
    check("pp_level_same", 64'(level), 64'd1);
    check("pp_ack", 64'(ack), 64'd1);
    drive(1'b0, '0, '1);
    cyc(); check("pp_gap", 64'(ack), 64'd0);
    cyc(); check("pp_ack2", 64'(ack), 64'd1);
    check("pp_level_end", 64'(level), 64'd0);
    drive(1'b0, '0, '0);

    // Fan-out: partial request issues nothing
    cyc(); drive(1'b1, 32'h33, '0);
    cyc(); drive(1'b0, '0, 3'b011);
    saw = 0;
    repeat (4) begin cyc(); if (ack) saw++; end
    check("t3_partial_ack", 64'(saw), 64'd0);
    check("t3_partial_level", 64'(level), 64'd1);
    drive(1'b0, '0, 3'b111);
    cyc();
    check("t3_full_ack", 64'(ack), 64'd1);
    check("t3_dout", 64'(dout), 64'h33);
    drive(1'b0, '0, '0);
    cyc();
    check("t3_level", 64'(level), 64'd0);

    // Held req, 4 words queued
    for (int i = 0; i < 4; i++) begin cyc(); drive(1'b1, 32'h40 + DW'(i), '0); end
    cyc(); drive(1'b0, '0, '1);
    repeat (20) cyc();
    check("t4_count", 64'(count), 64'd16);
    check("t4_acks", 64'(acks_seen), 64'd16);
    check("t4_level", 64'(level), 64'd0);
    check("t4_queue", 64'(exp_q.size()), 64'd0);
    drive(1'b0, '0, '0);

    // Reset mid-operation
    for (int i = 0; i < 6; i++) begin cyc(); drive(1'b1, 32'h60 + DW'(i), '0); end
    cyc(); drive(1'b0, '0, '1);
    cyc();
    check("t5_pre_ack", 64'(ack), 64'd1);
    check("t5_pre_level", 64'(level), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ack", 64'(ack), 64'd0);
    check("t5_rst_level", 64'(level), 64'd0);
    check("t5_rst_count", 64'(count), 64'd0);
    check("t5_rst_s_ready", 64'(s_ready), 64'd1);
    exp_q.delete();
    exp_count = '0;
    cyc();
    rst = 1'b0;
    drive(1'b1, 32'hA, '1);
    cyc(); drive(1'b0, '0, '1);
    wait_drain("t5_drain");
    check("t5_count", 64'(count), 64'd1);
    drive(1'b0, '0, '0);

    // Empty-FIFO latency (bypass vs FIFO path)
    cyc(); drive(1'b1, 32'h7, '1);
    cyc(); drive(1'b0, '0, '1);
`ifdef ARF_PULL_SOURCE_BYPASS_EN
    check("t6_ack_k", 64'(ack), 64'd1);
    check("t6_dout_k", 64'(dout), 64'h7);
    check("t6_level_k", 64'(level), 64'd0);
`else
    check("t6_ack_k", 64'(ack), 64'd0);
    check("t6_level_k", 64'(level), 64'd1);
`endif
    cyc();
`ifdef ARF_PULL_SOURCE_BYPASS_EN
    check("t6_ack_k1", 64'(ack), 64'd0);
`else
    check("t6_ack_k1", 64'(ack), 64'd1);
    check("t6_dout_k1", 64'(dout), 64'h7);
`endif
    check("t6_level_k1", 64'(level), 64'd0);
    drive(1'b0, '0, '0);
    cyc();
    wait_drain("final_drain");
    check("final_count", 64'(count), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, fails);
    $finish;
  end

endmodule
